// File: rtl/decodifica_hamming_secded.sv
// Pipelined Hamming SEC/SECDED decoder with a valid/ready stream interface.
// Stage 1 computes the syndrome and overall parity of the received word.
// Stage 2 classifies the error, corrects the data and presents the result.
// Saturating counters track corrected and uncorrectable words that the
// consumer actually accepted.
module decodifica_hamming_secded #(
    parameter int R      = 4,
    parameter int SECDED = 1,
    parameter int CONT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [(2**R)-1+SECDED-1:0]        entrada,
    input  logic                              entrada_valida,
    output logic                              entrada_pronta,
    output logic [(2**R)-1-R-1:0]             saida,
    output logic [R-1:0]                      sindrome,
    output logic                              erro_corrigido,
    output logic                              erro_nao_corrigivel,
    output logic                              saida_valida,
    input  logic                              saida_pronta,
    input  logic                              limpa_contadores,
    output logic [CONT_W-1:0]                 cont_corrigidos,
    output logic [CONT_W-1:0]                 cont_nao_corrigiveis
);

    localparam int N = (2**R) - 1;
    localparam int K = N - R;

    // Code position (1-based) that carries data bit k; data bits occupy
    // every position that is not a power of two, in ascending order.
    function automatic int posicaoDado(input int k);
        int contador;
        int resultado;
        contador  = 0;
        resultado = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (contador == k) begin
                    resultado = pos;
                end
                contador++;
            end
        end
        return resultado;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic avanca;
    logic handshake;

    // Stage 1 state
    logic [K-1:0] dados1_q,     dados1_d;
    logic         valido1_q,    valido1_d;
    logic [R-1:0] sindrome1_q,  sindrome1_d;
    logic         paridade1_q,  paridade1_d;

    // Stage 2 state (drives the outputs)
    logic [K-1:0] saida_q,      saida_d;
    logic [R-1:0] sindrome2_q,  sindrome2_d;
    logic         corrigido_q,  corrigido_d;
    logic         naoCorr_q,    naoCorr_d;
    logic         valido2_q,    valido2_d;

    // Counters
    logic [CONT_W-1:0] contCorr_q, contCorr_d;
    logic [CONT_W-1:0] contNao_q,  contNao_d;

    // Combinational helpers
    logic [K-1:0] dadosEntrada;
    logic [R-1:0] sindromeEntrada;
    logic         paridadeEntrada;
    logic         corrige;
    logic         naoCorrigivel;
    logic [K-1:0] dadosCorrigidos;

    assign avanca         = !valido2_q || saida_pronta;
    assign entrada_pronta = avanca;
    assign handshake      = valido2_q && saida_pronta;

    // ------------------------------------------------------------------
    // Stage 1: syndrome and overall parity of the incoming word
    // ------------------------------------------------------------------

    // Syndrome bit j is the XOR of every position whose index has bit j set.
    always_comb begin
        sindromeEntrada = '0;
        for (int pos = 1; pos <= N; pos++) begin
            for (int j = 0; j < R; j++) begin
                if (((pos >> j) & 1) == 1) begin
                    sindromeEntrada[j] = sindromeEntrada[j] ^ entrada[pos-1];
                end
            end
        end
    end

    assign paridadeEntrada = ^entrada;

    // Only the data positions need to travel down the pipe; the parity
    // positions are fully summarised by the syndrome and parity bits.
    for (genvar k = 0; k < K; k++) begin : g_dados
        localparam int P = posicaoDado(k);
        assign dadosEntrada[k]    = entrada[P-1];
        assign dadosCorrigidos[k] = dados1_q[k] ^ (corrige && (sindrome1_q == R'(P)));
    end

    // Stage 1 loads a new slot whenever the pipe advances, otherwise holds.
    always_comb begin
        dados1_d    = dados1_q;
        valido1_d   = valido1_q;
        sindrome1_d = sindrome1_q;
        paridade1_d = paridade1_q;
        if (avanca) begin
            dados1_d    = dadosEntrada;
            valido1_d   = entrada_valida;
            sindrome1_d = sindromeEntrada;
            paridade1_d = paridadeEntrada;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dados1_q    <= '0;
            valido1_q   <= 1'b0;
            sindrome1_q <= '0;
            paridade1_q <= 1'b0;
        end else begin
            dados1_q    <= dados1_d;
            valido1_q   <= valido1_d;
            sindrome1_q <= sindrome1_d;
            paridade1_q <= paridade1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: classification, correction and output registers
    // ------------------------------------------------------------------

    // With the extended bit, odd parity means a single error (possibly in
    // the extended bit itself when the syndrome is zero) and even parity
    // with a non-zero syndrome means a double error left uncorrected.
    always_comb begin
        corrige       = 1'b0;
        naoCorrigivel = 1'b0;
        if (SECDED != 0) begin
            if (paridade1_q) begin
                corrige = 1'b1;
            end else if (sindrome1_q != '0) begin
                naoCorrigivel = 1'b1;
            end
        end else if (sindrome1_q != '0) begin
            corrige = 1'b1;
        end
    end

    // Stage 2 captures the classified slot on advance; bubbles keep flags low.
    always_comb begin
        saida_d     = saida_q;
        sindrome2_d = sindrome2_q;
        corrigido_d = corrigido_q;
        naoCorr_d   = naoCorr_q;
        valido2_d   = valido2_q;
        if (avanca) begin
            saida_d     = dadosCorrigidos;
            sindrome2_d = sindrome1_q;
            corrigido_d = corrige && valido1_q;
            naoCorr_d   = naoCorrigivel && valido1_q;
            valido2_d   = valido1_q;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q     <= '0;
            sindrome2_q <= '0;
            corrigido_q <= 1'b0;
            naoCorr_q   <= 1'b0;
            valido2_q   <= 1'b0;
        end else begin
            saida_q     <= saida_d;
            sindrome2_q <= sindrome2_d;
            corrigido_q <= corrigido_d;
            naoCorr_q   <= naoCorr_d;
            valido2_q   <= valido2_d;
        end
    end

    assign saida               = saida_q;
    assign sindrome            = sindrome2_q;
    assign erro_corrigido      = corrigido_q;
    assign erro_nao_corrigivel = naoCorr_q;
    assign saida_valida        = valido2_q;

    // ------------------------------------------------------------------
    // Error statistics
    // ------------------------------------------------------------------

    // Counters step only on an accepted word, saturate at all-ones, and a
    // clear request overrides any increment in the same cycle.
    always_comb begin
        contCorr_d = contCorr_q;
        contNao_d  = contNao_q;
        if (limpa_contadores) begin
            contCorr_d = '0;
            contNao_d  = '0;
        end else if (handshake) begin
            if (corrigido_q && (contCorr_q != '1)) begin
                contCorr_d = contCorr_q + 1'b1;
            end
            if (naoCorr_q && (contNao_q != '1)) begin
                contNao_d = contNao_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contCorr_q <= '0;
            contNao_q  <= '0;
        end else begin
            contCorr_q <= contCorr_d;
            contNao_q  <= contNao_d;
        end
    end

    assign cont_corrigidos      = contCorr_q;
    assign cont_nao_corrigiveis = contNao_q;

endmodule

// File: tb/tb_decodifica_hamming_secded.sv
// Scoreboard bench for decodifica_hamming_secded (R=4, SECDED=1).
// Two instances share all inputs: one with 16-bit counters and one with
// 2-bit counters so saturation can be reached quickly.
module tb_decodifica_hamming_secded;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] entrada;
    logic        entrada_valida;
    logic        saida_pronta;
    logic        limpa_contadores;

    logic        entrada_pronta;
    logic [10:0] saida;
    logic [3:0]  sindrome;
    logic        erro_corrigido;
    logic        erro_nao_corrigivel;
    logic        saida_valida;
    logic [15:0] cont_corrigidos;
    logic [15:0] cont_nao_corrigiveis;

    logic        satEntradaPronta;
    logic [10:0] satSaida;
    logic [3:0]  satSindrome;
    logic        satErroCorrigido;
    logic        satErroNaoCorrigivel;
    logic        satSaidaValida;
    logic [1:0]  satContCorrigidos;
    logic [1:0]  satContNaoCorrigiveis;

    always #5 clk = ~clk;

    decodifica_hamming_secded #(.R(4), .SECDED(1), .CONT_W(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .entrada              (entrada),
        .entrada_valida       (entrada_valida),
        .entrada_pronta       (entrada_pronta),
        .saida                (saida),
        .sindrome             (sindrome),
        .erro_corrigido       (erro_corrigido),
        .erro_nao_corrigivel  (erro_nao_corrigivel),
        .saida_valida         (saida_valida),
        .saida_pronta         (saida_pronta),
        .limpa_contadores     (limpa_contadores),
        .cont_corrigidos      (cont_corrigidos),
        .cont_nao_corrigiveis (cont_nao_corrigiveis)
    );

    decodifica_hamming_secded #(.R(4), .SECDED(1), .CONT_W(2)) dutSat (
        .clk                  (clk),
        .rst_n                (rst_n),
        .entrada              (entrada),
        .entrada_valida       (entrada_valida),
        .entrada_pronta       (satEntradaPronta),
        .saida                (satSaida),
        .sindrome             (satSindrome),
        .erro_corrigido       (satErroCorrigido),
        .erro_nao_corrigivel  (satErroNaoCorrigivel),
        .saida_valida         (satSaidaValida),
        .saida_pronta         (saida_pronta),
        .limpa_contadores     (limpa_contadores),
        .cont_corrigidos      (satContCorrigidos),
        .cont_nao_corrigiveis (satContNaoCorrigiveis)
    );

    typedef struct packed {
        logic [10:0] d;
        logic [3:0]  s;
        logic        c;
        logic        u;
    } exp_t;

    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] expCorr;
    logic [15:0] expNao;
    logic [1:0]  expCorrSat;
    logic [1:0]  expNaoSat;

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        compared++;
        if (atual !== esperado) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Present one word and push its hand-computed result once it is accepted.
    task automatic applyStimulus(input logic [15:0] w, input logic [10:0] d,
                                 input logic [3:0] s, input logic c, input logic u);
        exp_t e;
        logic ok;
        e.d = d; e.s = s; e.c = c; e.u = u;
        ok = 1'b0;
        entrada        = w;
        entrada_valida = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (entrada_pronta) begin
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        checkOutput("word accepted", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        entrada_valida = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: checks counters every cycle against a small model and pops the
    // scoreboard on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            expCorr    = '0;
            expNao     = '0;
            expCorrSat = '0;
            expNaoSat  = '0;
        end else begin
            checkOutput("cont_corrigidos",         {16'd0, cont_corrigidos},       {16'd0, expCorr});
            checkOutput("cont_nao_corrigiveis",    {16'd0, cont_nao_corrigiveis},  {16'd0, expNao});
            checkOutput("sat cont_corrigidos",     {30'd0, satContCorrigidos},     {30'd0, expCorrSat});
            checkOutput("sat cont_nao_corrigiveis",{30'd0, satContNaoCorrigiveis}, {30'd0, expNaoSat});
            if (saida_valida && saida_pronta) begin
                checkOutput("word expected", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("saida",               {21'd0, saida},            {21'd0, e.d});
                    checkOutput("sindrome",            {28'd0, sindrome},         {28'd0, e.s});
                    checkOutput("erro_corrigido",      {31'd0, erro_corrigido},   {31'd0, e.c});
                    checkOutput("erro_nao_corrigivel", {31'd0, erro_nao_corrigivel}, {31'd0, e.u});
                    checkOutput("sat instance saida",  {21'd0, satSaida},         {21'd0, e.d});
                    if (e.c) begin
                        expCorr    = (expCorr == 16'hFFFF) ? expCorr : expCorr + 16'd1;
                        expCorrSat = (expCorrSat == 2'd3) ? expCorrSat : expCorrSat + 2'd1;
                    end
                    if (e.u) begin
                        expNao    = (expNao == 16'hFFFF) ? expNao : expNao + 16'd1;
                        expNaoSat = (expNaoSat == 2'd3) ? expNaoSat : expNaoSat + 2'd1;
                    end
                end
            end
            if (limpa_contadores) begin
                expCorr    = '0;
                expNao     = '0;
                expCorrSat = '0;
                expNaoSat  = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        entrada          = '0;
        entrada_valida   = 1'b0;
        saida_pronta     = 1'b1;
        limpa_contadores = 1'b0;

        // Reset state
        #12;
        checkOutput("reset saida",          {21'd0, saida},               32'd0);
        checkOutput("reset sindrome",       {28'd0, sindrome},            32'd0);
        checkOutput("reset erro_corrigido", {31'd0, erro_corrigido},      32'd0);
        checkOutput("reset erro_nao_corr",  {31'd0, erro_nao_corrigivel}, 32'd0);
        checkOutput("reset saida_valida",   {31'd0, saida_valida},        32'd0);
        checkOutput("reset entrada_pronta", {31'd0, entrada_pronta},      32'd1);
        checkOutput("reset cont_corr",      {16'd0, cont_corrigidos},     32'd0);
        checkOutput("reset cont_nao",       {16'd0, cont_nao_corrigiveis}, 32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean codewords back to back
        applyStimulus(16'h0000, 11'h000, 4'h0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 11'h7FF, 4'h0, 1'b0, 1'b0);
        drain();

        // Single error at position 5
        applyStimulus(16'hFFEF, 11'h7FF, 4'h5, 1'b1, 1'b0);
        drain();
        checkOutput("cont_corr after FFEF", {16'd0, cont_corrigidos}, 32'd1);

        // Extended-bit error, then a double error
        applyStimulus(16'h7FFF, 11'h7FF, 4'h0, 1'b1, 1'b0);
        applyStimulus(16'hFFFC, 11'h7FF, 4'h3, 1'b0, 1'b1);
        drain();
        checkOutput("cont_corr after 7FFF", {16'd0, cont_corrigidos},      32'd2);
        checkOutput("cont_nao after FFFC",  {16'd0, cont_nao_corrigiveis}, 32'd1);

        // Other data patterns
        applyStimulus(16'h8007, 11'h001, 4'h0, 1'b0, 1'b0);
        applyStimulus(16'hC08B, 11'h400, 4'h0, 1'b0, 1'b0);
        applyStimulus(16'h8003, 11'h001, 4'h3, 1'b1, 1'b0);
        applyStimulus(16'h021E, 11'h003, 4'hA, 1'b1, 1'b0);
        applyStimulus(16'h8118, 11'h012, 4'h8, 1'b0, 1'b1);
        drain();

        // Backpressure: three stalled cycles mid-stream
        fork
            begin
                applyStimulus(16'h8019, 11'h002, 4'h0, 1'b0, 1'b0);
                applyStimulus(16'h001E, 11'h003, 4'h0, 1'b0, 1'b0);
                applyStimulus(16'h8007, 11'h001, 4'h0, 1'b0, 1'b0);
                applyStimulus(16'hC08B, 11'h400, 4'h0, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                saida_pronta = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall entrada_pronta", {31'd0, entrada_pronta}, 32'd0);
                    checkOutput("stall saida_valida",   {31'd0, saida_valida},   32'd1);
                end
                @(posedge clk); #1;
                saida_pronta = 1'b1;
            end
        join
        drain();
        checkOutput("scoreboard empty after stall", sb.size(), 32'd0);

        // Clear without handshake, then saturate the 2-bit counter
        limpa_contadores = 1'b1;
        @(posedge clk); #1;
        limpa_contadores = 1'b0;
        @(negedge clk);
        checkOutput("cleared cont_corr", {16'd0, cont_corrigidos},      32'd0);
        checkOutput("cleared cont_nao",  {16'd0, cont_nao_corrigiveis}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(16'hFFEF, 11'h7FF, 4'h5, 1'b1, 1'b0);
        applyStimulus(16'hFFFE, 11'h7FF, 4'h1, 1'b1, 1'b0);
        applyStimulus(16'hBFFF, 11'h7FF, 4'hF, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 11'h7FF, 4'h0, 1'b1, 1'b0);
        applyStimulus(16'hFFDF, 11'h7FF, 4'h6, 1'b1, 1'b0);
        drain();
        checkOutput("sat counter at 3",   {30'd0, satContCorrigidos}, 32'd3);
        checkOutput("wide counter at 5",  {16'd0, cont_corrigidos},   32'd5);

        // Clear coincident with the handshake of an error word
        applyStimulus(16'hFFFB, 11'h7FF, 4'h3, 1'b1, 1'b0);
        @(posedge clk); #1;
        limpa_contadores = 1'b1;
        @(negedge clk);
        checkOutput("clear cycle valid",  {31'd0, saida_valida},   32'd1);
        checkOutput("clear cycle flag",   {31'd0, erro_corrigido}, 32'd1);
        @(posedge clk); #1;
        limpa_contadores = 1'b0;
        @(negedge clk);
        checkOutput("clear wins wide", {16'd0, cont_corrigidos},   32'd0);
        checkOutput("clear wins sat",  {30'd0, satContCorrigidos}, 32'd0);
        @(posedge clk); #1;

        // Reset with two words in flight
        applyStimulus(16'hFFEF, 11'h7FF, 4'h5, 1'b1, 1'b0);
        drain();
        applyStimulus(16'h8007, 11'h001, 4'h0, 1'b0, 1'b0);
        applyStimulus(16'hC08B, 11'h400, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset saida_valida", {31'd0, saida_valida},     32'd0);
        checkOutput("mid reset cont_corr",    {16'd0, cont_corrigidos},  32'd0);
        checkOutput("mid reset sat cont",     {30'd0, satContCorrigidos}, 32'd0);
        checkOutput("mid reset entrada_pronta", {31'd0, entrada_pronta}, 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of the first post-reset word
        applyStimulus(16'h8019, 11'h002, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("latency edge+1 not valid", {31'd0, saida_valida}, 32'd0);
        @(negedge clk);
        checkOutput("latency edge+2 valid",     {31'd0, saida_valida}, 32'd1);
        drain();
        checkOutput("scoreboard empty at end", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decodifica_hamming_secded.md
# decodifica_hamming_secded

Parametrised, pipelined Hamming SECDED decoder that generalises the 15/11 corrector to any number of parity bits, adds an optional extended-parity bit for double-error detection, and adds a valid/ready stream interface with error-statistics counters. It sits between the received-word buffer and the data consumer. It delivers corrected data words with per-word status and running counts of corrected and uncorrectable words.

## Interface
- `R`, 4: number of Hamming parity bits. N = 2^R−1 is the codeword length and K = N−R is the data width. Legal range 3..6.
- `SECDED`, 1: 1 appends an overall-parity bit at index N; 0 gives pure SEC.
- `CONT_W`, 16: width of each error counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `entrada`  in  N+SECDED  received word. Bit i holds code position i+1. Parity bits sit at positions 1, 2, 4, …, 2^(R−1). The extended parity bit, if present, is the MSB.
- `entrada_valida`  in  1  `entrada` is valid.
- `entrada_pronta`  out  1  block accepts a word this cycle.
- `saida`  out  K  corrected data: data positions in ascending order, so `saida[0]` is position 3.
- `sindrome`  out  R  syndrome of the delivered word.
- `erro_corrigido`  out  1  single error corrected, including an error in the extended bit.
- `erro_nao_corrigivel`  out  1  double error detected (SECDED=1 only).
- `saida_valida`  out  1  output word valid.
- `saida_pronta`  in  1  consumer accepts the output.
- `limpa_contadores`  in  1  synchronous clear of both counters.
- `cont_corrigidos`  out  CONT_W  saturating count of delivered words with `erro_corrigido`.
- `cont_nao_corrigiveis`  out  CONT_W  saturating count of delivered words with `erro_nao_corrigivel`.

## Operation
- Pipeline advance: `avanca = !saida_valida || saida_pronta`. `entrada_pronta = avanca`, combinational.
- Stage 1, on advance, registers:
  - the word;
  - `entrada_valida` as the stage valid;
  - the syndrome s. Bit j of s is the XOR of all positions whose index has bit j set, including parity position 2^j;
  - the overall parity p, the XOR of all N+SECDED bits.
- Stage 2, on advance, registers the stage-1 contents, classifies them and drives the outputs:
  - SECDED=1, s=0, p=0: no error. Both flags 0.
  - SECDED=1, s≠0, p=1: flip position s and set `erro_corrigido`.
  - SECDED=1, s=0, p=1: the extended bit itself is wrong. Data is unchanged; set `erro_corrigido`.
  - SECDED=1, s≠0, p=0: double error. Output the raw, uncorrected data bits and set `erro_nao_corrigivel`.
  - SECDED=0: s≠0 flips position s and sets `erro_corrigido`. `erro_nao_corrigivel` is constant 0.
- Every syndrome value 1..N is a valid position, so there is no out-of-range case.
- Counters update only on an output handshake (`saida_valida && saida_pronta`). Each increments by 1 when its flag is set and saturates at 2^CONT_W−1.
- If `limpa_contadores` and an increment occur in the same cycle, the clear wins: the result is 0.
- Invalid stage-1 slots (bubbles) propagate as `saida_valida=0`. They are not compressed.

## Timing
- Reset values: `saida`=0, `sindrome`=0, both flags=0, `saida_valida`=0, stage-1 valid=0, both counters=0. `entrada_pronta`=1 while reset is asserted and after it is released.
- Latency: a word accepted at edge t appears with `saida_valida=1` after edge t+1, provided there is no stall. Throughput is 1 word/cycle.
- Stall (`saida_valida=1`, `saida_pronta=0`): both stages hold and `entrada_pronta=0`. Outputs stay stable until the handshake.
- Reset asserted mid-stream discards all words in flight. The counters clear.

## Test plan
- R=4, SECDED=1. Send 16'h0000, then 16'hFFFF, with `saida_pronta`=1 → two cycles later `saida` = 11'h000, then 11'h7FF. Flags 0, `sindrome`=0. Back-to-back, one word per cycle.
- Send 16'hFFEF (index 4 flipped) → `saida`=11'h7FF, `sindrome`=4'h5, `erro_corrigido`=1, and `cont_corrigidos` goes to 1 after the handshake.
- Send 16'h7FFF → `saida`=11'h7FF, `sindrome`=0, `erro_corrigido`=1. Send 16'hFFFC → `saida`=11'h7FF (raw), `sindrome`=4'h3, `erro_nao_corrigivel`=1, `cont_nao_corrigiveis`=1.
- Backpressure: stream 4 words with `saida_pronta` low for 3 cycles mid-stream → no word lost or duplicated, `entrada_pronta` low while stalled, order preserved.
- CONT_W=2: send 5 single-error words → `cont_corrigidos` saturates at 3. Pulse `limpa_contadores` in the same cycle as a handshake of an error word → counter reads 0.
- Assert `rst_n` low with 2 words in flight → `saida_valida`=0 and counters are 0 immediately. The first post-reset word emerges with latency 2.
